// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: fills the pipe after reset, stalls every stage during
// data-memory operations and flushes decode/execute after a taken BR/JMP.
module lc3_pipe_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        complete_data,
   input  logic [15:0] IR,
   input  logic [2:0]  psr,
   output logic        enable_fetch,
   output logic        enable_updatePC,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic [1:0]  mem_state,
   output logic        mem_err
);

   localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

   localparam logic [1:0] MS_RD   = 2'b00;
   localparam logic [1:0] MS_WR   = 2'b01;
   localparam logic [1:0] MS_IND  = 2'b10;
   localparam logic [1:0] MS_IDLE = 2'b11;

   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [4:0] EN_FETCH = 5'b11000;
   localparam logic [4:0] EN_ALL   = 5'b11111;

   typedef enum logic [2:0] {
      S_FILL, S_RUN, S_MEM_IND, S_MEM_RD, S_MEM_WR, S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        fill_cnt_q, fill_cnt_d;
   logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              resume_q, resume_d;
   logic              ind_st_q, ind_st_d;
   // Enable bit order: fetch, updatePC, decode, execute, writeback
   logic [4:0]        en_q, en_d;
   logic              br_q, br_d;
   logic [1:0]        ms_q, ms_d;
   logic              err_q, err_d;

   logic [3:0]        opc;
   logic              is_ld, is_ind, is_st, is_taken;
   logic [WCNT_W-1:0] wait_inc;
   logic              timeout;
   logic              ir_unused;

   assign opc       = IR[15:12];
   assign ir_unused = ^IR[8:0];

   always_comb begin
      is_ld    = (opc == 4'b0010) || (opc == 4'b0110);
      is_ind   = (opc == 4'b1010) || (opc == 4'b1011);
      is_st    = (opc == 4'b0011) || (opc == 4'b0111);
      is_taken = ((opc == 4'b0000) && (|(IR[11:9] & psr))) || (opc == 4'b1100);
      wait_inc = wait_cnt_q + WCNT_W'(1);
      timeout  = (MEM_TIMEOUT > 0) && !complete_data && (wait_inc == TMO);
   end

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      resume_d    = 1'b0;
      ind_st_d    = ind_st_q;
      en_d        = en_q;
      br_d        = 1'b0;
      ms_d        = ms_q;
      err_d       = err_q;
      case (state_q)
         S_FILL: begin
            fill_cnt_d = fill_cnt_q + 2'd1;
            case (fill_cnt_q)
               2'd0:    en_d = 5'b11000;
               2'd1:    en_d = 5'b11100;
               2'd2:    en_d = 5'b11110;
               default: begin
                  en_d       = EN_ALL;
                  fill_cnt_d = 2'd0;
                  state_d    = S_RUN;
               end
            endcase
         end
         S_RUN: begin
            en_d = EN_ALL;
            ms_d = MS_IDLE;
            // The instruction that just finished is still in IR on the resume cycle
            if (!resume_q) begin
               if (is_ld) begin
                  state_d    = S_MEM_RD;
                  ms_d       = MS_RD;
                  en_d       = EN_NONE;
                  wait_cnt_d = '0;
               end else if (is_ind) begin
                  state_d    = S_MEM_IND;
                  ms_d       = MS_IND;
                  en_d       = EN_NONE;
                  wait_cnt_d = '0;
                  ind_st_d   = IR[12];
               end else if (is_st) begin
                  state_d    = S_MEM_WR;
                  ms_d       = MS_WR;
                  en_d       = EN_NONE;
                  wait_cnt_d = '0;
               end else if (is_taken) begin
                  state_d     = S_FLUSH;
                  br_d        = 1'b1;
                  en_d        = EN_FETCH;
                  flush_cnt_d = FCNT_W'(FLUSH_CYCLES);
               end
            end
         end
         S_MEM_IND: begin
            if (complete_data) begin
               state_d    = ind_st_q ? S_MEM_WR : S_MEM_RD;
               ms_d       = ind_st_q ? MS_WR : MS_RD;
               wait_cnt_d = '0;
            end else if (timeout) begin
               state_d    = S_RUN;
               ms_d       = MS_IDLE;
               en_d       = EN_ALL;
               resume_d   = 1'b1;
               err_d      = 1'b1;
               wait_cnt_d = '0;
            end else if (MEM_TIMEOUT > 0) begin
               wait_cnt_d = wait_inc;
            end
         end
         S_MEM_RD, S_MEM_WR: begin
            if (complete_data || timeout) begin
               state_d    = S_RUN;
               ms_d       = MS_IDLE;
               en_d       = EN_ALL;
               resume_d   = 1'b1;
               wait_cnt_d = '0;
               if (timeout) err_d = 1'b1;
            end else if (MEM_TIMEOUT > 0) begin
               wait_cnt_d = wait_inc;
            end
         end
         S_FLUSH: begin
            en_d = EN_FETCH;
            if (flush_cnt_q <= FCNT_W'(1)) begin
               state_d     = S_RUN;
               en_d        = EN_ALL;
               resume_d    = 1'b1;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - FCNT_W'(1);
            end
         end
         default: begin
            state_d = S_FILL;
            en_d    = EN_NONE;
            ms_d    = MS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FILL;
         fill_cnt_q  <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
         resume_q    <= 1'b0;
         ind_st_q    <= 1'b0;
         en_q        <= EN_NONE;
         br_q        <= 1'b0;
         ms_q        <= MS_IDLE;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         resume_q    <= resume_d;
         ind_st_q    <= ind_st_d;
         en_q        <= en_d;
         br_q        <= br_d;
         ms_q        <= ms_d;
         err_q       <= err_d;
      end
   end

   assign enable_fetch     = en_q[4];
   assign enable_updatePC  = en_q[3];
   assign enable_decode    = en_q[2];
   assign enable_execute   = en_q[1];
   assign enable_writeback = en_q[0];
   assign br_taken         = br_q;
   assign mem_state        = ms_q;
   assign mem_err          = err_q;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Scoreboard bench for lc3_pipe_controller: a cycle model pushes expected outputs
// when inputs are driven; a monitor pops and compares after each rising edge.
module tb_lc3_pipe_controller;

   localparam int FLUSH = 2;
   localparam int TMO   = 4;

   localparam int M_FILL  = 0;
   localparam int M_RUN   = 1;
   localparam int M_IND   = 2;
   localparam int M_RD    = 3;
   localparam int M_WR    = 4;
   localparam int M_FLUSH = 5;

   logic        clock;
   logic        reset;
   logic        complete_data;
   logic [15:0] IR;
   logic [2:0]  psr;
   logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        mem_err;

   typedef struct packed {
      logic [4:0] en;
      logic       br;
      logic [1:0] ms;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc   = 0;

   int         m_mode, m_fill, m_flush, m_wait;
   logic       m_resume, m_store, m_br, m_err;
   logic [4:0] m_en;
   logic [1:0] m_ms;

   lc3_pipe_controller #(.FLUSH_CYCLES(FLUSH), .MEM_TIMEOUT(TMO)) dut (
      .clock            (clock),
      .reset            (reset),
      .complete_data    (complete_data),
      .IR               (IR),
      .psr              (psr),
      .enable_fetch     (enable_fetch),
      .enable_updatePC  (enable_updatePC),
      .enable_decode    (enable_decode),
      .enable_execute   (enable_execute),
      .enable_writeback (enable_writeback),
      .br_taken         (br_taken),
      .mem_state        (mem_state),
      .mem_err          (mem_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cyc, got, want);
      end
   endtask

   function automatic logic [4:0] dut_en();
      return {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback};
   endfunction

   task automatic model_reset();
      m_mode = M_FILL; m_fill = 0; m_flush = 0; m_wait = 0;
      m_resume = 1'b0; m_store = 1'b0; m_br = 1'b0; m_err = 1'b0;
      m_en = 5'b00000; m_ms = 2'b11;
   endtask

   task automatic go_mem(input int mode, input logic [1:0] ms);
      m_mode = mode; m_ms = ms; m_en = 5'b00000; m_wait = 0;
   endtask

   task automatic back_to_run();
      m_mode = M_RUN; m_ms = 2'b11; m_en = 5'b11111; m_resume = 1'b1;
   endtask

   task automatic model_step();
      logic [3:0] op;
      exp_t e;
      op = IR[15:12];
      m_br = 1'b0;
      case (m_mode)
         M_FILL: begin
            m_fill++;
            m_en = (m_fill == 1) ? 5'b11000 : (m_fill == 2) ? 5'b11100 :
                   (m_fill == 3) ? 5'b11110 : 5'b11111;
            if (m_fill == 4) begin m_mode = M_RUN; m_fill = 0; end
         end
         M_RUN: begin
            m_en = 5'b11111; m_ms = 2'b11;
            if (m_resume) m_resume = 1'b0;
            else if (op == 4'h2 || op == 4'h6) go_mem(M_RD, 2'b00);
            else if (op == 4'hA || op == 4'hB) begin m_store = (op == 4'hB); go_mem(M_IND, 2'b10); end
            else if (op == 4'h3 || op == 4'h7) go_mem(M_WR, 2'b01);
            else if ((op == 4'h0 && (IR[11:9] & psr) != 3'b000) || op == 4'hC) begin
               m_mode = M_FLUSH; m_flush = FLUSH; m_br = 1'b1; m_en = 5'b11000;
            end
         end
         M_IND, M_RD, M_WR: begin
            m_wait++;
            if (complete_data) begin
               if (m_mode == M_IND) begin
                  if (m_store) go_mem(M_WR, 2'b01);
                  else go_mem(M_RD, 2'b00);
               end else back_to_run();
            end else if (TMO > 0 && m_wait == TMO) begin
               m_err = 1'b1;
               back_to_run();
            end
         end
         default: begin
            m_flush--;
            if (m_flush == 0) back_to_run();
         end
      endcase
      e.en = m_en; e.br = m_br; e.ms = m_ms; e.err = m_err;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic [15:0] ir, input logic [2:0] p, input logic cd);
      @(negedge clock);
      IR = ir; psr = p; complete_data = cd;
      model_step();
      @(posedge clock);
      #2;
   endtask

   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         n_cyc++;
         mon_e = exp_q.pop_front();
         check("enables", 16'(dut_en()), 16'(mon_e.en));
         check("br_taken", 16'(br_taken), 16'(mon_e.br));
         check("mem_state", 16'(mem_state), 16'(mon_e.ms));
         check("mem_err", 16'(mem_err), 16'(mon_e.err));
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"}, 16'(dut_en()), 16'h0);
      check({tag, "_br"}, 16'(br_taken), 16'h0);
      check({tag, "_ms"}, 16'(mem_state), 16'h3);
      check({tag, "_err"}, 16'(mem_err), 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      IR = 16'h1000; psr = 3'b000; complete_data = 1'b0;
      reset = 1'b1;
      model_reset();
      #1 reset = 1'b0;
      #1 check_reset_outputs("rst0");
      repeat (2) @(posedge clock);
      #2 check_reset_outputs("rst_hold");
      reset = 1'b1;

      // Fill sequence, then steady run
      repeat (6) cyc(16'h1000, 3'b000, 1'b0);
      check("fill_done", 16'(dut_en()), 16'h1f);

      // LDR with completion on the fourth wait cycle (also the timeout boundary)
      cyc(16'h6000, 3'b000, 1'b0);
      check("ldr_ms", 16'(mem_state), 16'h0);
      repeat (3) cyc(16'h6000, 3'b000, 1'b0);
      cyc(16'h6000, 3'b000, 1'b1);
      cyc(16'h6000, 3'b000, 1'b0);
      check("ldr_no_retrigger", 16'(mem_state), 16'h3);
      repeat (2) cyc(16'h1000, 3'b000, 1'b0);

      // STI: address read then write
      cyc(16'hB000, 3'b000, 1'b0);
      cyc(16'hB000, 3'b000, 1'b0);
      cyc(16'hB000, 3'b000, 1'b1);
      check("sti_write", 16'(mem_state), 16'h1);
      cyc(16'hB000, 3'b000, 1'b0);
      cyc(16'hB000, 3'b000, 1'b0);
      cyc(16'hB000, 3'b000, 1'b1);
      cyc(16'hB000, 3'b000, 1'b0);
      cyc(16'h1000, 3'b000, 1'b1);

      // LDI path back through MEM_RD
      cyc(16'hA000, 3'b000, 1'b0);
      cyc(16'hA000, 3'b000, 1'b1);
      cyc(16'hA000, 3'b000, 1'b1);
      cyc(16'hA000, 3'b000, 1'b0);
      cyc(16'h1000, 3'b000, 1'b0);

      // BRn taken, then not taken, then JMP
      cyc(16'h0800, 3'b100, 1'b0);
      check("brn_pulse", 16'(br_taken), 16'h1);
      repeat (3) cyc(16'h0800, 3'b100, 1'b0);
      repeat (3) cyc(16'h0800, 3'b010, 1'b0);
      cyc(16'hC000, 3'b000, 1'b0);
      repeat (3) cyc(16'h1000, 3'b000, 1'b0);

      // ST and STR
      cyc(16'h3000, 3'b000, 1'b0);
      cyc(16'h3000, 3'b000, 1'b1);
      cyc(16'h3000, 3'b000, 1'b0);
      cyc(16'h7000, 3'b000, 1'b1);
      cyc(16'h7000, 3'b000, 1'b1);
      cyc(16'h1000, 3'b000, 1'b0);

      // LD with no completion: timeout sets the sticky error
      repeat (6) cyc(16'h2000, 3'b000, 1'b0);
      check("timeout_err", 16'(mem_err), 16'h1);
      repeat (3) cyc(16'h1000, 3'b000, 1'b0);
      check("err_sticky", 16'(mem_err), 16'h1);

      // Asynchronous reset in the middle of MEM_RD
      repeat (3) cyc(16'h2000, 3'b000, 1'b0);
      reset = 1'b0;
      #1 check_reset_outputs("rst_mid");
      model_reset();
      @(posedge clock);
      #2 reset = 1'b1;
      repeat (5) cyc(16'h1000, 3'b000, 1'b0);

      // Random instruction mix
      for (int i = 0; i < 60; i++) begin
         logic [15:0] pick [12];
         pick = '{16'h1000, 16'h6000, 16'h2000, 16'hB000, 16'hA000, 16'h3000,
                  16'h7000, 16'h0800, 16'h0E00, 16'h0400, 16'hC000, 16'h5000};
         cyc(pick[$urandom_range(11)], 3'($urandom_range(7)), ($urandom_range(9) < 4));
      end

      @(negedge clock);
      check("sb_drained", 16'(exp_q.size()), 16'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
